// File: rtl/seq_mult_param.sv
// seq_mult_param: iterative radix-2 shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Signed operands are converted to magnitudes, multiplied unsigned, and the sign
// is restored in a final FIX cycle. Fixed latency is WIDTH+1 cycles.
// Optional macro SEQ_MULT_EARLY_TERM_EN: leave CALC as soon as the remaining
// multiplier bits are zero and realign the accumulator in FIX.
module seq_mult_param #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SIGNED,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             OVF
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // acc holds the partial product; its upper WIDTH bits receive the adds
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0]   mcand_reg, mcand_next;
  logic [WIDTH-1:0]   mplier_reg, mplier_next;
  logic               neg_reg, neg_next;
  logic               sgn_reg, sgn_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [WIDTH-1:0]   hi_reg, hi_next;
  logic [WIDTH-1:0]   lo_reg, lo_next;
  logic               ovf_reg, ovf_next;
  logic               done_reg, done_next;

  // datapath helpers
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   add_val;
  logic [WIDTH:0]     step_hi;
  logic [2*WIDTH-1:0] step_acc;
  logic [CNT_W-1:0]   step_cnt;
  logic               last_step;
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod;

  // operand magnitudes; the most negative value maps to 2^(WIDTH-1), which fits unsigned
  always_comb begin
    a_mag = (SIGNED && A[WIDTH-1]) ? (~A + WIDTH'(1)) : A;
    b_mag = (SIGNED && B[WIDTH-1]) ? (~B + WIDTH'(1)) : B;
  end

  // one shift-add step: add multiplicand into the top half, then shift right by one
  always_comb begin
    add_val  = mplier_reg[0] ? mcand_reg : '0;
    step_hi  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, add_val};
    step_acc = {step_hi, acc_reg[WIDTH-1:1]};
    step_cnt = cnt_reg + CNT_W'(1);
`ifdef SEQ_MULT_EARLY_TERM_EN
    last_step = (step_cnt == CNT_W'(WIDTH)) || ((mplier_reg >> 1) == '0);
`else
    last_step = (step_cnt == CNT_W'(WIDTH));
`endif
  end

`ifdef SEQ_MULT_EARLY_TERM_EN
  logic [CNT_W-1:0] skip_cnt;

  // an early exit skipped (WIDTH - cnt) pure-shift steps; apply them in one go
  always_comb begin
    skip_cnt = CNT_W'(WIDTH) - cnt_reg;
    prod_mag = acc_reg >> skip_cnt;
  end
`else
  // full run: accumulator already holds the unsigned product
  always_comb begin
    prod_mag = acc_reg;
  end
`endif

  // restore the sign of the product
  always_comb begin
    prod = neg_reg ? (~prod_mag + (2*WIDTH)'(1)) : prod_mag;
  end

  // next-state and register-next logic for the IDLE -> CALC -> FIX sequence
  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    neg_next    = neg_reg;
    sgn_next    = sgn_reg;
    cnt_next    = cnt_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    ovf_next    = ovf_reg;
    done_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (START) begin
          mcand_next  = a_mag;
          mplier_next = b_mag;
          neg_next    = SIGNED & (A[WIDTH-1] ^ B[WIDTH-1]);
          sgn_next    = SIGNED;
          acc_next    = '0;
          cnt_next    = '0;
          state_next  = CALC;
        end
      end
      CALC: begin
        acc_next    = step_acc;
        mplier_next = mplier_reg >> 1;
        cnt_next    = step_cnt;
        if (last_step) begin
          state_next = FIX;
        end
      end
      FIX: begin
        hi_next    = prod[2*WIDTH-1:WIDTH];
        lo_next    = prod[WIDTH-1:0];
        if (sgn_reg) begin
          ovf_next = (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
        end else begin
          ovf_next = (prod[2*WIDTH-1:WIDTH] != '0);
        end
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // state register; reset wins over any operation in flight
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg  <= IDLE;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      neg_reg    <= 1'b0;
      sgn_reg    <= 1'b0;
      cnt_reg    <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      ovf_reg    <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      neg_reg    <= neg_next;
      sgn_reg    <= sgn_next;
      cnt_reg    <= cnt_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      ovf_reg    <= ovf_next;
      done_reg   <= done_next;
    end
  end

  assign BUSY = (state_reg != IDLE);
  assign DONE = done_reg;
  assign HI   = hi_reg;
  assign LO   = lo_reg;
  assign OVF  = ovf_reg;

endmodule

// File: tb/tb_seq_mult_param.sv
// tb_seq_mult_param: scoreboard bench for seq_mult_param at WIDTH=32.
// Expected products come from native 64-bit arithmetic; expected latency
// follows the build (SEQ_MULT_EARLY_TERM_EN selects the early-exit timing).
module tb_seq_mult_param;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         START = 1'b0;
  logic         SIGNED = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         BUSY, DONE, OVF;
  logic [W-1:0] HI, LO;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         ovf;
    int           lat;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int op_id  = 0;

  seq_mult_param #(.WIDTH(W), .CNT_W(6)) dut (
    .CLK(CLK), .RST(RST), .START(START), .SIGNED(SIGNED), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .HI(HI), .LO(LO), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference product, overflow and latency for one operation
  function automatic exp_t model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic signed [63:0] sa, sb;
    logic [63:0] p;
    logic [W-1:0] bm;
    int h;
    if (sgn) begin
      sa = {{W{a[W-1]}}, a};
      sb = {{W{b[W-1]}}, b};
      p  = sa * sb;
      e.ovf = (p[63:32] != {W{p[31]}});
    end else begin
      p  = {32'b0, a} * {32'b0, b};
      e.ovf = (p[63:32] != 32'b0);
    end
    e.hi = p[63:32];
    e.lo = p[31:0];
    bm = (sgn && b[W-1]) ? (~b + 32'd1) : b;
    h = 0;
    for (int i = 0; i < W; i++) if (bm[i]) h = i;
`ifdef SEQ_MULT_EARLY_TERM_EN
    e.lat = h + 2;
`else
    e.lat = W + 1;
`endif
    return e;
  endfunction

  // Called at #1 after a rising edge. ev_at>0 injects a START (ev_rst=0)
  // or a reset (ev_rst=1) across the ev_at-th edge after acceptance.
  task automatic do_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int ev_at, input bit ev_rst);
    exp_t e, got_e;
    int n;
    bit got_done;
    bit done_ever;
    op_id++;
    e = model(sgn, a, b);
    exp_q.push_back(e);
    START = 1'b1; SIGNED = sgn; A = a; B = b;
    @(posedge CLK); #1;
    START = 1'b0; SIGNED = ~sgn; A = $urandom; B = $urandom;
    check("busy_after_start", {63'b0, BUSY}, 64'd1);
    check("done_is_pulse", {63'b0, DONE}, 64'd0);
    got_done = 1'b0;
    for (n = 1; n <= 100; n++) begin
      if (n == ev_at) begin
        if (ev_rst) RST = 1'b1;
        else begin
          START = 1'b1; SIGNED = ~sgn; A = 32'h0000_1234; B = 32'h0000_5678;
        end
      end
      @(posedge CLK); #1;
      RST = 1'b0; START = 1'b0;
      if (ev_rst && n == ev_at) break;
      if (DONE) begin got_done = 1'b1; break; end
    end
    if (ev_rst) begin
      void'(exp_q.pop_front());
      check("rst_busy", {63'b0, BUSY}, 64'd0);
      check("rst_done", {63'b0, DONE}, 64'd0);
      check("rst_hi", {32'b0, HI}, 64'd0);
      check("rst_lo", {32'b0, LO}, 64'd0);
      done_ever = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(posedge CLK); #1;
        if (DONE) done_ever = 1'b1;
      end
      check("no_done_after_rst", {63'b0, done_ever}, 64'd0);
      $display("op %0d: sgn=%0d a=0x%08h b=0x%08h aborted by reset at iteration %0d",
               op_id, sgn, a, b, ev_at);
      return;
    end
    check("done_seen", {63'b0, got_done}, 64'd1);
    got_e = exp_q.pop_front();
    check("latency", 64'(n), 64'(got_e.lat));
    check("hi", {32'b0, HI}, {32'b0, got_e.hi});
    check("lo", {32'b0, LO}, {32'b0, got_e.lo});
    check("ovf", {63'b0, OVF}, {63'b0, got_e.ovf});
    check("busy_at_done", {63'b0, BUSY}, 64'd0);
    $display("op %0d: sgn=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h ovf=%0d lat=%0d",
             op_id, sgn, a, b, HI, LO, OVF, n);
  endtask

  initial begin
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    check("reset_busy", {63'b0, BUSY}, 64'd0);
    check("reset_done", {63'b0, DONE}, 64'd0);
    check("reset_hi", {32'b0, HI}, 64'd0);
    check("reset_lo", {32'b0, LO}, 64'd0);
    check("reset_ovf", {63'b0, OVF}, 64'd0);
    @(posedge CLK); #1;

    do_op(1'b0, 32'd5, 32'd3, 0, 1'b0);
    do_op(1'b1, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    do_op(1'b0, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    do_op(1'b1, 32'hFFFF_FFF6, 32'hFFFF_FFFB, 0, 1'b0);
    do_op(1'b1, 32'hFFFF_FFF4, 32'd2, 0, 1'b0);
    do_op(1'b1, 32'h8000_0000, 32'h8000_0000, 0, 1'b0);
    do_op(1'b0, 32'h0001_0000, 32'h0001_0000, 0, 1'b0);
    do_op(1'b0, 32'd7, 32'd2, 0, 1'b0);
    do_op(1'b1, 32'hFFFF_FFFD, 32'd0, 0, 1'b0);
    do_op(1'b0, 32'd0, 32'hDEAD_BEEF, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      do_op(1'(i % 2), $urandom, $urandom, 0, 1'b0);
    end
    // START mid-operation must be ignored
    do_op(1'b1, 32'hFFFF_0123, 32'hF000_0007, 5, 1'b0);
    // reset mid-operation aborts without DONE
    do_op(1'b0, 32'h1234_5678, 32'h8765_4321, 10, 1'b1);
    // fresh operation after the abort
    do_op(1'b0, 32'hCAFE_F00D, 32'h9ABC_DEF1, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mult_param.md
Name: seq_mult_param

Overview:
- Parametrised iterative multiplier: WIDTH x WIDTH -> 2*WIDTH product, split into HI/LO halves.
- Per-operation signed/unsigned mode, start/busy/done handshake and an overflow flag.
- Successor to the combinational 32-bit signed multiplier; sits beside the ALU in the datapath.
- Trades latency (WIDTH+1 cycles) for one adder and registers.

Parameters:
- WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  request; accepted only when BUSY=0.
- SIGNED  input  1  1 = two's-complement operands, 0 = unsigned; sampled with START.
- A  input  WIDTH  multiplicand; sampled with START.
- B  input  WIDTH  multiplier; sampled with START.
- BUSY  output  1  high while an operation is in flight.
- DONE  output  1  one-cycle pulse; HI/LO/OVF valid from this cycle.
- HI  output  WIDTH  upper half of product.
- LO  output  WIDTH  lower half of product.
- OVF  output  1  product not representable in LO alone.

Behaviour:
- Reset (RST=1 at an edge): state IDLE; BUSY=0, DONE=0, HI=0, LO=0, OVF=0; counter and internal registers cleared. Reset has priority over everything, including mid-operation. An aborted operation never produces DONE.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE: at an edge with START=1, latch operands.
  - SIGNED=1: store magnitudes |A| and |B|, plus neg = A[msb] XOR B[msb].
  - SIGNED=0: store A and B unchanged, neg=0.
  - Clear accumulator and counter; go to CALC; BUSY=1 from the next cycle.
- CALC, one radix-2 shift-add step per edge:
  - If current multiplier LSB = 1, add multiplicand to the upper WIDTH+1 bits of the accumulator.
  - Shift accumulator/multiplier right by 1; increment counter.
  - After WIDTH iterations, go to FIX.
- FIX, one edge: product P = neg ? -acc : acc, 2*WIDTH bits.
  - Register HI=P[2W-1:W] and LO=P[W-1:0].
  - Register OVF:
    - Signed: HI != sign-extension of LO[msb].
    - Unsigned: HI != 0.
  - DONE=1 for exactly one cycle; BUSY=0; go to IDLE.
- Latency: START accepted at edge k -> DONE high in the cycle following edge k+WIDTH+1 (33 cycles at WIDTH=32).
- HI/LO/OVF hold their values until the next FIX or reset.
- START while BUSY=1: ignored; operands are not re-sampled.
- START in the same cycle DONE=1: accepted, since state is already IDLE.
- Most-negative operands: magnitude 2^(WIDTH-1) fits in WIDTH unsigned bits. Example: (-2^31)*(-2^31) = 2^62 exactly; OVF=1.
- Zero operand: runs the full sequence; result 0, OVF=0.

Optional Feature:
- Macro: SEQ_MULT_EARLY_TERM_EN.
- Defined: after each CALC step, if the remaining multiplier bits are all zero, jump directly to FIX. The accumulator is aligned by the count of skipped positions so the result equals the full run.
  - At least one iteration always occurs.
  - DONE timing: edge k + (index of highest set magnitude bit of B) + 2.
  - B=0 -> DONE after edge k+2.
- Undefined: fixed WIDTH+1 latency; no alignment shifter synthesised.
- HI/LO/OVF values are identical in both builds.

Test Plan:
- Unsigned 5*3, START at edge k -> DONE after edge k+33; HI=0x00000000, LO=0x0000000F, OVF=0.
- 0xFFFFFFFF*1:
  - Signed -> HI=0xFFFFFFFF, LO=0xFFFFFFFF, OVF=0.
  - Unsigned -> HI=0x00000000, LO=0xFFFFFFFF, OVF=0.
- Signed 0xFFFFFFF6*0xFFFFFFFB (-10*-5) -> HI=0, LO=0x00000032. Signed 0xFFFFFFF4*2 -> HI=0xFFFFFFFF, LO=0xFFFFFFE8, OVF=0.
- Signed 0x80000000*0x80000000 -> HI=0x40000000, LO=0x00000000, OVF=1. Unsigned 0x10000*0x10000 -> HI=1, LO=0, OVF=1.
- Mid-operation events:
  - START pulsed at iteration 5 with new operands -> ignored; result matches the original operands.
  - RST at iteration 10 -> next cycle BUSY=0, HI=LO=0; no DONE follows.
  - Fresh START then completes correctly.
- With SEQ_MULT_EARLY_TERM_EN: unsigned 7*2 -> DONE after edge k+3, LO=14. Same stimulus without the macro -> DONE after edge k+33, same LO.
